// File: rtl/pipe_pkg.sv
// Shared types and defaults for the decode-stage issue control block.
package pipe_pkg;

    localparam int unsigned ADDR_W         = 5;
    localparam int unsigned PIPE_DEPTH     = 3;
    localparam int unsigned BRANCH_PENALTY = 2;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
    } sb_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FIRE,
        HOLD
    } int_state_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Writeback scoreboard: one entry per in-flight stage, shifted every cycle,
// with two address match ports and an all-invalid flag.
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int unsigned PIPE_DEPTH = pipe_pkg::PIPE_DEPTH,
    parameter int unsigned ADDR_W     = pipe_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [ADDR_W-1:0] x_addr,
    input  logic [ADDR_W-1:0] y_addr,
    output logic              hit_x,
    output logic              hit_y,
    output logic              empty
);

    logic [PIPE_DEPTH-1:0] valid;
    logic [ADDR_W-1:0]     addr [PIPE_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
                addr[i] <= '0;
            end
        end else begin
            valid[0] <= push_valid;
            addr[0]  <= push_addr;
            for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
                valid[i] <= valid[i-1];
                addr[i]  <= addr[i-1];
            end
        end
    end

    always_comb begin
        hit_x = 1'b0;
        hit_y = 1'b0;
        for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
            if (valid[i] && addr[i] == x_addr) hit_x = 1'b1;
            if (valid[i] && addr[i] == y_addr) hit_y = 1'b1;
        end
    end

    assign empty = (valid == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage issue control: RAW stalls, branch flush bubbles and the
// interrupt drain/fire sequence. Optional perf counters under HAZARD_PERF_EN.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned PIPE_DEPTH     = pipe_pkg::PIPE_DEPTH,
    parameter int unsigned ADDR_W         = pipe_pkg::ADDR_W,
    parameter int unsigned BRANCH_PENALTY = pipe_pkg::BRANCH_PENALTY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_x_used,
    input  logic [ADDR_W-1:0] id_x_addr,
    input  logic              id_y_used,
    input  logic [ADDR_W-1:0] id_y_addr,
    input  logic              id_rf_wr,
    input  logic [ADDR_W-1:0] id_wb_addr,
    input  logic              ex_branch_taken,
    input  logic              int_req,
    input  logic              int_en,
`ifdef HAZARD_PERF_EN
    output logic [15:0]       perf_stall_cnt,
    output logic [15:0]       perf_flush_cnt,
`endif
    output logic              nop,
    output logic              stall_fetch,
    output logic              flush_ifid,
    output logic              interupt,
    output logic              int_ack
);

    localparam logic [2:0] PENALTY = 3'(BRANCH_PENALTY);

    logic       hit_x;
    logic       hit_y;
    logic       sb_empty;
    logic       hazard;
    logic       flush;
    logic       issue;
    logic [2:0] flush_cnt;

    int_state_t state;
    int_state_t state_next;

    hazard_scoreboard #(
        .PIPE_DEPTH (PIPE_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .push_valid (issue & id_rf_wr),
        .push_addr  (id_wb_addr),
        .x_addr     (id_x_addr),
        .y_addr     (id_y_addr),
        .hit_x      (hit_x),
        .hit_y      (hit_y),
        .empty      (sb_empty)
    );

    assign flush  = (flush_cnt != '0);
    assign hazard = id_valid & ((id_x_used & hit_x) | (id_y_used & hit_y));
    assign issue  = id_valid & ~hazard & ~flush & (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt <= '0;
        end else if (ex_branch_taken) begin
            flush_cnt <= PENALTY;
        end else if (flush) begin
            flush_cnt <= flush_cnt - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (int_req && int_en && !flush && !ex_branch_taken) state_next = DRAIN;
            end
            DRAIN: begin
                // A branch resolving this cycle reloads the flush counter, so wait it out.
                if (!int_en) state_next = IDLE;
                else if (sb_empty && !flush && !ex_branch_taken) state_next = FIRE;
            end
            FIRE: state_next = HOLD;
            HOLD: begin
                if (!int_req) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are held low while reset is asserted, before state has cleared.
    always_comb begin
        nop         = 1'b0;
        stall_fetch = 1'b0;
        flush_ifid  = 1'b0;
        interupt    = 1'b0;
        int_ack     = 1'b0;
        if (!rst) begin
            nop         = flush | hazard | (state == DRAIN);
            stall_fetch = ~flush & (hazard | (state == DRAIN) | (state == FIRE));
            flush_ifid  = flush;
            interupt    = (state == FIRE);
            int_ack     = (state == FIRE);
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (hazard && !flush && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 16'd1;
            if (flush && perf_flush_cnt != '1) perf_flush_cnt <= perf_flush_cnt + 16'd1;
        end
    end
`endif

endmodule
